// File: rtl/button_select_latch.sv
// ---------------------------------------------------------------------------
// button_select_latch
//   N-button selection latch for the game front end. Each raw button is
//   synchronised, debounced and rising-edge detected. The most recent
//   accepted press becomes the current selection (one-hot and binary index)
//   unless lock is high. A one-cycle strobe flags every selection change.
//
// Ports
//   clk        in   system clock, rising edge
//   rst_n      in   synchronous active-low reset
//   buttons    in   [NUM_BUTTONS] raw asynchronous buttons, active-high
//   lock       in   freezes the selection while high
//   selection  out  [SEL_WIDTH] one-hot current selection
//   sel_index  out  [IDX_WIDTH] binary index of the current selection
//   changed    out  one-cycle pulse when the selection value changes
//   press      out  [NUM_BUTTONS] one-cycle pulse per accepted rising edge
// ---------------------------------------------------------------------------

// Per-button front end: 2-flop synchroniser, debounce counter, rise detect.
// rise_o is combinational from lane registers only; the top registers it.
module btn_lane #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_i,
    output logic rise_o
);
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             deb_q, deb_d;
    logic             deb_dly_q;

    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            // The DEBOUNCE_CYCLES-th consecutive differing sample flips the level.
            if (cnt_q == CNT_MAX) begin
                deb_d = sync2_q;
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
        end else begin
            sync1_q   <= btn_i;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
        end
    end

    assign rise_o = deb_q & ~deb_dly_q;
endmodule

module button_select_latch #(
    parameter int NUM_BUTTONS     = 3,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int SEL_WIDTH       = 4,
    parameter int IDX_WIDTH       = 2,
    parameter int RESET_SEL       = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_BUTTONS-1:0] buttons,
    input  logic                   lock,
    output logic [SEL_WIDTH-1:0]   selection,
    output logic [IDX_WIDTH-1:0]   sel_index,
    output logic                   changed,
    output logic [NUM_BUTTONS-1:0] press
);
    localparam logic [SEL_WIDTH-1:0] SEL_RST = SEL_WIDTH'(1) << RESET_SEL;
    localparam logic [IDX_WIDTH-1:0] IDX_RST = IDX_WIDTH'(RESET_SEL);

    logic [NUM_BUTTONS-1:0] rise;
    logic                   cand_vld;
    logic [IDX_WIDTH-1:0]   cand_idx;

    logic [SEL_WIDTH-1:0]   sel_q, sel_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   chg_q, chg_d;
    logic [NUM_BUTTONS-1:0] press_q;

    for (genvar g = 0; g < NUM_BUTTONS; g++) begin : g_lane
        btn_lane #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lane (
            .clk    (clk),
            .rst_n  (rst_n),
            .btn_i  (buttons[g]),
            .rise_o (rise[g])
        );
    end

    // Lowest index wins: scan downward so the last hit is the smallest.
    always_comb begin
        cand_vld = 1'b0;
        cand_idx = '0;
        for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
            if (rise[i]) begin
                cand_vld = 1'b1;
                cand_idx = IDX_WIDTH'(i);
            end
        end
    end

    // Presses seen while locked are dropped, never queued.
    always_comb begin
        sel_d = sel_q;
        idx_d = idx_q;
        chg_d = 1'b0;
        if (cand_vld && !lock && (cand_idx != idx_q)) begin
            sel_d = SEL_WIDTH'(1) << cand_idx;
            idx_d = cand_idx;
            chg_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel_q   <= SEL_RST;
            idx_q   <= IDX_RST;
            chg_q   <= 1'b0;
            press_q <= '0;
        end else begin
            sel_q   <= sel_d;
            idx_q   <= idx_d;
            chg_q   <= chg_d;
            press_q <= rise;
        end
    end

    assign selection = sel_q;
    assign sel_index = idx_q;
    assign changed   = chg_q;
    assign press     = press_q;
endmodule
